// File: rtl/minibyte_bus_responder_if.sv
// Minibyte CPU <-> responder bus: 7-bit address, 8-bit data both ways, write strobe and drive flags.
// The CPU is the master. The responder drives data_out and drive_out.
interface minibyte_bus_responder_if;
  logic [6:0] addr_in;
  logic [7:0] data_in;
  logic       we_in;
  logic       cpu_drive_in;
  logic [7:0] data_out;
  logic       drive_out;

  modport master (
    output addr_in, data_in, we_in, cpu_drive_in,
    input  data_out, drive_out
  );

  modport slave (
    input  addr_in, data_in, we_in, cpu_drive_in,
    output data_out, drive_out
  );
endinterface

// File: rtl/minibyte_bus_responder.sv
// Minibyte bus target: RAM, GPIO out/in pair and an optional 8-bit timer with interrupt.
// Define MINIBYTE_RESP_TIMER_EN to build the timer. Without it, 0x7E/0x7F act as unmapped.
module minibyte_bus_responder #(
  parameter int RAM_DEPTH  = 64,
  parameter int PRESCALE_W = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  minibyte_bus_responder_if.slave     bus,
  input  logic [7:0]                  gpio_in,
  output logic [7:0]                  gpio_out,
  output logic                        irq_out
);

  localparam logic [6:0] ADDR_GPIO_OUT = 7'h7C;
  localparam logic [6:0] ADDR_GPIO_IN  = 7'h7D;
  localparam logic [6:0] ADDR_TMR_CNT  = 7'h7E;
  localparam logic [6:0] ADDR_TMR_CTRL = 7'h7F;
  localparam logic [6:0] RAM_TOP       = 7'(RAM_DEPTH);
  localparam int         RAM_AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int         RAM_SLOTS     = 2 ** RAM_AW;

  logic [7:0] ram_q [0:RAM_SLOTS-1];
  logic [7:0] data_q, data_d;
  logic       drive_q, drive_d;
  logic [7:0] gpio_q, gpio_d;
  logic [7:0] sync1_q, sync2_q;
  logic [7:0] rd_data;
  logic [7:0] tmr_rd;
  logic       in_ram;

  assign in_ram        = (bus.addr_in < RAM_TOP);
  assign bus.data_out  = data_q;
  assign bus.drive_out = drive_q;
  assign gpio_out      = gpio_q;

  // RAM has no reset; gating with rst_in drops a write caught by an async reset.
  always_ff @(posedge clk_in) begin
    if (rst_in && bus.we_in && in_ram) begin
      ram_q[bus.addr_in[RAM_AW-1:0]] <= bus.data_in;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.addr_in)
      ADDR_GPIO_OUT: rd_data = gpio_q;
      ADDR_GPIO_IN:  rd_data = sync2_q;
      ADDR_TMR_CNT,
      ADDR_TMR_CTRL: rd_data = tmr_rd;
      default: begin
        if (in_ram) rd_data = ram_q[bus.addr_in[RAM_AW-1:0]];
      end
    endcase
  end

  always_comb begin
    data_d  = bus.we_in ? bus.data_in : rd_data;
    drive_d = ~bus.we_in & ~bus.cpu_drive_in;
    gpio_d  = gpio_q;
    if (bus.we_in && bus.addr_in == ADDR_GPIO_OUT) gpio_d = bus.data_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_q  <= 8'h00;
      drive_q <= 1'b0;
      gpio_q  <= 8'h00;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      data_q  <= data_d;
      drive_q <= drive_d;
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef MINIBYTE_RESP_TIMER_EN
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            reload_q, reload_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  en_q, en_d, ar_q, ar_d, ie_q, ie_d, ovf_q, ovf_d;
  logic                  wr_cnt, wr_ctrl, tick, wrap;

  assign wr_cnt  = bus.we_in && (bus.addr_in == ADDR_TMR_CNT);
  assign wr_ctrl = bus.we_in && (bus.addr_in == ADDR_TMR_CTRL);
  assign tick    = en_q & (&presc_q);
  assign wrap    = tick & (cnt_q == 8'hFF);
  assign tmr_rd  = (bus.addr_in == ADDR_TMR_CNT) ? cnt_q
                                                 : {ovf_q, ie_q, 4'b0000, ar_q, en_q};
  assign irq_out = ovf_q & ie_q;

  // A CNT write overrides a same-edge tick, including the overflow that tick would cause.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    en_d     = en_q;
    ar_d     = ar_q;
    ie_d     = ie_q;
    ovf_d    = ovf_q;
    if (wr_cnt) begin
      cnt_d    = bus.data_in;
      reload_d = bus.data_in;
      presc_d  = '0;
    end else if (en_q) begin
      presc_d = presc_q + PRESCALE_W'(1);
      if (tick) cnt_d = wrap ? (ar_q ? reload_q : 8'h00) : cnt_q + 8'd1;
    end
    if (wr_ctrl) begin
      en_d = bus.data_in[0];
      ar_d = bus.data_in[1];
      ie_d = bus.data_in[6];
      if (bus.data_in[7]) ovf_d = 1'b0;
    end
    if (wrap && !wr_cnt) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q    <= 8'h00;
      reload_q <= 8'h00;
      presc_q  <= '0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = PRESCALE_W[0];
  assign tmr_rd          = 8'h00;
  assign irq_out         = 1'b0;
`endif

endmodule
